pb_debounce: RTL

Synchronises and debounces the raw breakout-board pushbutton and produces the clean `PB` level consumed by the LED demo stage. It also supplies single-cycle press/release strobes and a press-toggled level for later demos. It sits between the pushbutton pin and every downstream consumer of `PB`. It is fully synchronous to `CLK` apart from the asynchronous reset.

---
 rtl/pb_debounce_if.sv | 25 ++
 rtl/pb_debounce.sv | 120 ++++++++++++
 2 files changed

// File: rtl/pb_debounce_if.sv
// Pushbutton debouncer bundle: raw pin in, clean level and strobes out.
// master = whatever drives the pin (board/bench), slave = the debouncer.
interface pb_debounce_if;
  logic pb_raw;
  logic pb;
  logic press;
  logic rel;
  logic toggle;

  modport master (
    output pb_raw,
    input  pb,
    input  press,
    input  rel,
    input  toggle
  );

  modport slave (
    input  pb_raw,
    output pb,
    output press,
    output rel,
    output toggle
  );
endinterface

// File: rtl/pb_debounce.sv
// Two-flop synchroniser plus a four-state qualification FSM that turns the raw
// pushbutton into a clean level, press/release strobes and a press toggle.
module pb_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_WIDTH       = 16
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  pb_debounce_if.slave  pb_if
);

  typedef enum logic [1:0] {
    LO_STABLE = 2'd0,
    WAIT_HI   = 2'd1,
    HI_STABLE = 2'd2,
    WAIT_LO   = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic                 r_s1;
  logic                 r_s2;
  state_t               r_state;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_pb;
  logic                 r_press;
  logic                 r_rel;
  logic                 r_toggle;

  state_t               w_state_next;
  logic [CNT_WIDTH-1:0] w_cnt_next;
  logic                 w_pb_next;
  logic                 w_press_next;
  logic                 w_rel_next;
  logic                 w_toggle_next;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= pb_if.pb_raw;
      r_s2 <= r_s1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= LO_STABLE;
      r_cnt    <= '0;
      r_pb     <= 1'b0;
      r_press  <= 1'b0;
      r_rel    <= 1'b0;
      r_toggle <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_cnt    <= w_cnt_next;
      r_pb     <= w_pb_next;
      r_press  <= w_press_next;
      r_rel    <= w_rel_next;
      r_toggle <= w_toggle_next;
    end
  end

  // Strobes default low so they can only ever last the single acceptance cycle.
  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    w_pb_next     = r_pb;
    w_press_next  = 1'b0;
    w_rel_next    = 1'b0;
    w_toggle_next = r_toggle;
    case (r_state)
      LO_STABLE: begin
        if (r_s2) begin
          w_state_next = WAIT_HI;
          w_cnt_next   = '0;
        end
      end
      WAIT_HI: begin
        if (!r_s2) begin
          w_state_next = LO_STABLE;
        end else if (r_cnt == CNT_MAX) begin
          w_state_next  = HI_STABLE;
          w_pb_next     = 1'b1;
          w_press_next  = 1'b1;
          w_toggle_next = ~r_toggle;
        end else begin
          w_cnt_next = r_cnt + CNT_WIDTH'(1);
        end
      end
      HI_STABLE: begin
        if (!r_s2) begin
          w_state_next = WAIT_LO;
          w_cnt_next   = '0;
        end
      end
      WAIT_LO: begin
        if (r_s2) begin
          w_state_next = HI_STABLE;
        end else if (r_cnt == CNT_MAX) begin
          w_state_next = LO_STABLE;
          w_pb_next    = 1'b0;
          w_rel_next   = 1'b1;
        end else begin
          w_cnt_next = r_cnt + CNT_WIDTH'(1);
        end
      end
      default: begin
        w_state_next = LO_STABLE;
      end
    endcase
  end

  assign pb_if.pb     = r_pb;
  assign pb_if.press  = r_press;
  assign pb_if.rel    = r_rel;
  assign pb_if.toggle = r_toggle;

endmodule
